// File: rtl/calc_operand_entry.sv
// Calculator operand entry sequencer: conditions the enter/clear buttons and captures A, B and operator.
// Optional debounce filters are built only when CALC_DEBOUNCE_EN is defined.
module calc_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       op_sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [3:0] operand1,
  output logic [3:0] operand2,
  output logic       operator_sel,
  output logic       operands_valid,
  output logic [1:0] entry_state
);

  typedef enum logic [1:0] {
    GET_A  = 2'd0,
    GET_B  = 2'd1,
    GET_OP = 2'd2,
    SHOW   = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_invalid
  end

  // Bit 0 carries the enter button, bit 1 the clear button.
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] deb;
  logic [1:0] deb_d;
  logic [1:0] pulse;
  logic [1:0] lock;
  logic [1:0] settle;
  logic       enter_p;
  logic       clear_p;

  // Two-flop synchroniser, edge detector and post-reset lockout for both buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
      deb_d  <= 2'b00;
      pulse  <= 2'b00;
      lock   <= 2'b11;
      settle <= 2'd0;
    end else begin
      sync_a <= {btn_clear, btn_enter};
      sync_b <= sync_a;
      deb_d  <= deb;
      if (settle != 2'd2) begin
        settle <= settle + 2'd1;
      end else begin
        settle <= settle;
      end
      // A button still held from before reset stays locked until seen released.
      for (int i = 0; i < 2; i++) begin
        if ((settle == 2'd2) && !sync_b[i] && !deb[i]) begin
          lock[i] <= 1'b0;
        end else begin
          lock[i] <= lock[i];
        end
        pulse[i] <= deb[i] & ~deb_d[i] & ~lock[i];
      end
    end
  end

`ifdef CALC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt [2];

  // Accept a level change only after it has held for DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb    <= 2'b00;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  assign deb = sync_b;
`endif

  assign enter_p = pulse[0];
  assign clear_p = pulse[1];

  state_t     state;
  state_t     state_n;
  logic [3:0] operand1_n;
  logic [3:0] operand2_n;
  logic       operator_sel_n;
  logic       operands_valid_n;

  // State and captured-value registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= GET_A;
      operand1       <= 4'd0;
      operand2       <= 4'd0;
      operator_sel   <= 1'b0;
      operands_valid <= 1'b0;
    end else begin
      state          <= state_n;
      operand1       <= operand1_n;
      operand2       <= operand2_n;
      operator_sel   <= operator_sel_n;
      operands_valid <= operands_valid_n;
    end
  end

  // Next-state and capture decode; clear takes priority over enter.
  always_comb begin
    state_n          = state;
    operand1_n       = operand1;
    operand2_n       = operand2;
    operator_sel_n   = operator_sel;
    operands_valid_n = operands_valid;
    if (clear_p) begin
      state_n          = GET_A;
      operand1_n       = 4'd0;
      operand2_n       = 4'd0;
      operator_sel_n   = 1'b0;
      operands_valid_n = 1'b0;
    end else if (enter_p) begin
      case (state)
        GET_A, SHOW: begin
          operand1_n       = sw;
          operands_valid_n = 1'b0;
          state_n          = GET_B;
        end
        GET_B: begin
          operand2_n = sw;
          state_n    = GET_OP;
        end
        GET_OP: begin
          operator_sel_n   = op_sw;
          operands_valid_n = 1'b1;
          state_n          = SHOW;
        end
        default: begin
          state_n = GET_A;
        end
      endcase
    end else begin
      state_n = state;
    end
  end

  assign entry_state = state;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Directed self-checking bench for calc_operand_entry with DEBOUNCE_CYCLES = 4.
// Expected latency follows whether CALC_DEBOUNCE_EN is defined for this build.
module tb_calc_operand_entry;

  localparam int D = 4;
`ifdef CALC_DEBOUNCE_EN
  localparam int LAT = 3 + D;
  localparam int DB  = D;
`else
  localparam int LAT = 3;
  localparam int DB  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = 4'd0;
  logic       op_sw = 1'b0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] operand1;
  logic [3:0] operand2;
  logic       operator_sel;
  logic       operands_valid;
  logic [1:0] entry_state;

  int checks = 0;
  int errors = 0;

  // {operand1, operand2, operator_sel, operands_valid, entry_state}
  logic [11:0] snap;
  assign snap = {operand1, operand2, operator_sel, operands_valid, entry_state};

  calc_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw),
    .btn_enter(btn_enter), .btn_clear(btn_clear),
    .operand1(operand1), .operand2(operand2), .operator_sel(operator_sel),
    .operands_valid(operands_valid), .entry_state(entry_state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_enter(input logic [3:0] s, input logic o);
    sw = s;
    op_sw = o;
    btn_enter = 1'b1;
    tick(LAT + 2);
    btn_enter = 1'b0;
    tick(DB + 6);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL reset_hold: got %h expected %h", snap, 12'h000); end
    rst = 1'b0;
    tick(5);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL reset_idle: got %h expected %h", snap, 12'h000); end
  endtask

  task automatic test_full_entry;
    sw = 4'd9;
    btn_enter = 1'b1;
    tick(LAT);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL a_early: got %h expected %h", snap, 12'h000); end
    tick(1);
    checks++;
    if (snap !== 12'h901) begin errors++; $display("FAIL a_capture: got %h expected %h", snap, 12'h901); end
    tick(2);
    btn_enter = 1'b0;
    tick(DB + 6);
    sw = 4'd3;
    tick(5);
    checks++;
    if (snap !== 12'h901) begin errors++; $display("FAIL sw_static: got %h expected %h", snap, 12'h901); end
    press_enter(4'd12, 1'b1);
    checks++;
    if (snap !== 12'h9C2) begin errors++; $display("FAIL b_capture: got %h expected %h", snap, 12'h9C2); end
    press_enter(4'd1, 1'b0);
    checks++;
    if (snap !== 12'h9C7) begin errors++; $display("FAIL op_capture: got %h expected %h", snap, 12'h9C7); end
    checks++;
    if (entry_state !== 2'd3) begin errors++; $display("FAIL show_state: got %0d expected %0d", entry_state, 2'd3); end
  endtask

  task automatic test_restart;
    press_enter(4'd5, 1'b0);
    checks++;
    if (snap !== 12'h5C1) begin errors++; $display("FAIL restart: got %h expected %h", snap, 12'h5C1); end
    press_enter(4'd7, 1'b0);
    checks++;
    if (snap !== 12'h572) begin errors++; $display("FAIL restart_b: got %h expected %h", snap, 12'h572); end
    press_enter(4'd0, 1'b1);
    checks++;
    if (snap !== 12'h57F) begin errors++; $display("FAIL add_op: got %h expected %h", snap, 12'h57F); end
  endtask

  task automatic test_clear_priority;
    press_enter(4'd2, 1'b0);
    checks++;
    if (snap !== 12'h279) begin errors++; $display("FAIL pre_clear_a: got %h expected %h", snap, 12'h279); end
    press_enter(4'd6, 1'b0);
    checks++;
    if (snap !== 12'h26A) begin errors++; $display("FAIL pre_clear_b: got %h expected %h", snap, 12'h26A); end
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    tick(LAT + 2);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL clear_priority: got %h expected %h", snap, 12'h000); end
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    tick(DB + 6);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL clear_release: got %h expected %h", snap, 12'h000); end
  endtask

  task automatic test_bounce;
`ifdef CALC_DEBOUNCE_EN
    sw = 4'd10;
    btn_enter = 1'b1; tick(3);
    btn_enter = 1'b0; tick(2);
    btn_enter = 1'b1; tick(3);
    btn_enter = 1'b0; tick(12);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL bounce_reject: got %h expected %h", snap, 12'h000); end
`endif
  endtask

  task automatic test_hold;
    sw = 4'd8;
    btn_enter = 1'b1;
    tick(LAT);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL hold_early: got %h expected %h", snap, 12'h000); end
    tick(1);
    checks++;
    if (snap !== 12'h801) begin errors++; $display("FAIL hold_capture: got %h expected %h", snap, 12'h801); end
    tick(9 - LAT);
    btn_enter = 1'b0;
    tick(DB + 8);
    checks++;
    if (snap !== 12'h801) begin errors++; $display("FAIL hold_single: got %h expected %h", snap, 12'h801); end
  endtask

  task automatic test_reset_mid_entry;
    sw = 4'd13;
    btn_enter = 1'b1;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL mid_reset: got %h expected %h", snap, 12'h000); end
    tick(15);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL held_through_reset: got %h expected %h", snap, 12'h000); end
    btn_enter = 1'b0;
    tick(DB + 8);
    checks++;
    if (snap !== 12'h000) begin errors++; $display("FAIL release_after_reset: got %h expected %h", snap, 12'h000); end
    press_enter(4'd11, 1'b0);
    checks++;
    if (snap !== 12'hB01) begin errors++; $display("FAIL repress_after_reset: got %h expected %h", snap, 12'hB01); end
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_restart();
    test_clear_priority();
    test_bounce();
    test_hold();
    test_reset_mid_entry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
